// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller for the CNN datapath: reset, start, one frame of pixels, result handoff.
// Optional watchdog on the result wait is built when SEQ_TIMEOUT_EN is defined.
module cnn_frame_sequencer #(
   parameter int unsigned FRAME_PIXELS   = 1024,
   parameter int unsigned RST_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        s_pix_valid,
   input  logic [7:0]  s_pix_data,
   input  logic        s_pix_last,
   output logic        s_pix_ready,
   output logic        cnn_rst,
   output logic        cnn_start,
   output logic        cnn_pixel_valid,
   output logic [7:0]  cnn_pixel,
   input  logic        cnn_result_valid,
   input  logic [47:0] cnn_result,
   output logic        m_res_valid,
   output logic [47:0] m_res_data,
   input  logic        m_res_ready,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic        err_framing,
   output logic        err_timeout
);

   localparam int unsigned PW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
   localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(FRAME_PIXELS - 1);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

   typedef enum logic [2:0] {
      S_CNN_RST,
      S_IDLE,
      S_START,
      S_STREAM,
      S_WAIT_RES,
      S_OUTPUT
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [PW-1:0] pix_cnt;
   logic [RW-1:0] rst_cnt;
   logic          accept;
   logic          final_beat;
   logic          early_last;
   logic          capture;
   logic          deliver;
   logic          wd_expired;

   // Ready is a pure state decode so upstream sees it without a register stage.
   assign s_pix_ready = (state == S_STREAM);

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      final_beat = 1'b0;
      early_last = 1'b0;
      capture    = 1'b0;
      deliver    = 1'b0;
      case (state)
         S_CNN_RST: if (rst_cnt == RST_LAST) next_state = S_IDLE;
         S_IDLE:    if (enable) next_state = S_START;
         S_START:   next_state = S_STREAM;
         S_STREAM: begin
            if (s_pix_valid) begin
               accept = 1'b1;
               if (pix_cnt == LAST_IDX) begin
                  final_beat = 1'b1;
                  next_state = S_WAIT_RES;
               end else if (s_pix_last) begin
                  early_last = 1'b1;
                  next_state = S_CNN_RST;
               end
            end
         end
         S_WAIT_RES: begin
            if (cnn_result_valid) begin
               capture    = 1'b1;
               next_state = S_OUTPUT;
            end else if (wd_expired) begin
               next_state = S_CNN_RST;
            end
         end
         S_OUTPUT: begin
            if (m_res_ready) begin
               deliver    = 1'b1;
               next_state = S_CNN_RST;
            end
         end
         default: next_state = S_CNN_RST;
      endcase
   end

   // Status outputs are registered from next_state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= S_CNN_RST;
         rst_cnt         <= '0;
         pix_cnt         <= '0;
         cnn_rst         <= 1'b1;
         cnn_start       <= 1'b0;
         cnn_pixel_valid <= 1'b0;
         cnn_pixel       <= '0;
         m_res_valid     <= 1'b0;
         m_res_data      <= '0;
         busy            <= 1'b0;
         frame_cnt       <= '0;
         err_framing     <= 1'b0;
      end else begin
         state           <= next_state;
         rst_cnt         <= (state == S_CNN_RST && next_state == S_CNN_RST) ? rst_cnt + 1'b1 : '0;
         if (state == S_START)
            pix_cnt <= '0;
         else if (accept)
            pix_cnt <= pix_cnt + 1'b1;
         cnn_rst         <= (next_state == S_CNN_RST);
         cnn_start       <= (next_state == S_START);
         m_res_valid     <= (next_state == S_OUTPUT);
         busy            <= (next_state != S_IDLE);
         cnn_pixel_valid <= accept & ~early_last;
         if (accept && !early_last)
            cnn_pixel <= s_pix_data;
         if (capture)
            m_res_data <= cnn_result;
         if (deliver)
            frame_cnt <= frame_cnt + 16'd1;
         err_framing     <= early_last | (final_beat & ~s_pix_last);
      end
   end

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WW-1:0] wd_cnt;

   assign wd_expired = (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         wd_cnt      <= '0;
         err_timeout <= 1'b0;
      end else begin
         wd_cnt      <= (state == S_WAIT_RES) ? wd_cnt + 1'b1 : '0;
         err_timeout <= (state == S_WAIT_RES) & ~cnn_result_valid & wd_expired;
      end
   end
`else
   assign wd_expired  = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule
